// File: rtl/xm23_pipe_pkg.sv
// Shared constants for the XM23 pipeline hazard controller: enable-vector bit positions,
// stall-vector bit positions and the controller FSM state type.
package xm23_pipe_pkg;

  localparam int unsigned EN_W = 41;

  localparam int unsigned EN_ALU_A_LO = 9;
  localparam int unsigned EN_ALU_A_HI = 13;
  localparam int unsigned EN_ALU_B_LO = 15;
  localparam int unsigned EN_ALU_B_HI = 17;
  localparam int unsigned EN_ALU_C_LO = 19;
  localparam int unsigned EN_ALU_C_HI = 27;
  localparam int unsigned EN_MOV_LO   = 35;
  localparam int unsigned EN_MOV_HI   = 38;
  localparam int unsigned EN_LD       = 33;
  localparam int unsigned EN_ST       = 34;
  localparam int unsigned EN_LDR      = 39;

  localparam int unsigned STALL_RAW_EX  = 0;
  localparam int unsigned STALL_RAW_MEM = 1;
  localparam int unsigned STALL_RAW_WB  = 2;
  localparam int unsigned STALL_MEM     = 3;
  localparam int unsigned STALL_SLEEP   = 4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2,
    SLEEP    = 2'd3
  } pipe_state_t;

  function automatic logic [EN_W-1:0] range_mask(input int unsigned lo, input int unsigned hi);
    return ({EN_W{1'b1}} << lo) & ({EN_W{1'b1}} >> (EN_W - 1 - hi));
  endfunction

  // Instructions that always write their D register.
  localparam logic [EN_W-1:0] WR_MASK =
      range_mask(EN_ALU_A_LO, EN_ALU_A_HI) |
      range_mask(EN_ALU_B_LO, EN_ALU_B_HI) |
      range_mask(EN_ALU_C_LO, EN_ALU_C_HI) |
      range_mask(EN_MOV_LO, EN_MOV_HI) |
      range_mask(EN_LD, EN_LD) |
      range_mask(EN_LDR, EN_LDR);

endpackage

// File: rtl/pipeline_hazard_ctrl_raw_compare.sv
// Per-stage RAW detector: flags when a decode source register is written by this stage's
// instruction, including pointer write-back of LD (S) and ST (D).
module raw_compare
  import xm23_pipe_pkg::*;
(
  input  logic [EN_W-1:0] i_enable,
  input  logic [2:0]      i_d,
  input  logic [2:0]      i_s,
  input  logic            i_ptr_upd,
  input  logic            i_src_d_vld,
  input  logic [2:0]      i_src_d,
  input  logic            i_src_s_vld,
  input  logic [2:0]      i_src_s,
  output logic            o_hazard
);

  logic w_wr_base;
  logic w_dst_d;
  logic w_dst_s;
  logic w_hit_d;
  logic w_hit_s;

  assign w_wr_base = |(i_enable & WR_MASK);
  assign w_dst_d   = w_wr_base | (i_enable[EN_ST] & i_ptr_upd);
  assign w_dst_s   = i_enable[EN_LD] & i_ptr_upd;

  assign w_hit_d = i_src_d_vld &
                   ((w_dst_d & (i_src_d == i_d)) | (w_dst_s & (i_src_d == i_s)));
  assign w_hit_s = i_src_s_vld &
                   ((w_dst_d & (i_src_s == i_d)) | (w_dst_s & (i_src_s == i_s)));

  assign o_hazard = w_hit_d | w_hit_s;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// XM23 pipeline hazard controller: RAW stalls, data-memory waits, branch-fail flush and SLP sleep.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipeline_hazard_ctrl
  import xm23_pipe_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
`ifdef PIPE_CTRL_PERF_EN
  , parameter int PERF_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [EN_W-1:0]  dec_enable,
  input  logic [2:0]       dec_D,
  input  logic [2:0]       dec_S,
  input  logic             dec_rd_d,
  input  logic             dec_rd_s,
  input  logic             dec_RC,
  input  logic [2:0][EN_W-1:0] stg_enable,
  input  logic [2:0][2:0]  stg_D,
  input  logic [2:0][2:0]  stg_S,
  input  logic [2:0]       stg_ptr_upd,
  input  logic [2:0]       stg_slp,
  input  logic             branch_fail,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  input  logic             wake,
  output logic [7:0]       stall_o,
  output logic             clear_o,
  output logic             fetch_hold_o,
  output logic [1:0]       state_o
`ifdef PIPE_CTRL_PERF_EN
  , output logic [PERF_W-1:0] perf_stall_o
  , output logic [PERF_W-1:0] perf_flush_o
`endif
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  pipe_state_t      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_pend, w_pend_nxt;
  logic [7:0]       w_stall;
  logic             w_clear;
  logic [2:0]       w_raw;
  logic             w_unused;

  // Only the wb copy of SLP triggers sleep; earlier copies are carried for symmetry.
  assign w_unused = ^stg_slp[1:0];

  for (genvar g = 0; g < 3; g++) begin : g_stage
    raw_compare u_cmp (
      .i_enable    (stg_enable[g]),
      .i_d         (stg_D[g]),
      .i_s         (stg_S[g]),
      .i_ptr_upd   (stg_ptr_upd[g]),
      .i_src_d_vld (dec_rd_d),
      .i_src_d     (dec_D),
      .i_src_s_vld (dec_rd_s & ~dec_RC),
      .i_src_s     (dec_S),
      .o_hazard    (w_raw[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend;
    w_stall     = '0;
    w_clear     = 1'b0;
    unique case (r_state)
      RUN: begin
        w_stall[STALL_RAW_WB:STALL_RAW_EX] = w_raw & {3{|dec_enable}};
        if (branch_fail) begin
          w_state_nxt = FLUSH;
          w_cnt_nxt   = CNT_LOAD;
        end else if (dmem_req & ~dmem_ack) begin
          w_state_nxt        = MEM_WAIT;
          w_stall[STALL_MEM] = 1'b1;
        end else if (stg_slp[2] & |stg_enable[2]) begin
          w_state_nxt = SLEEP;
        end
      end
      FLUSH: begin
        w_clear = 1'b1;
        if (branch_fail) begin
          w_cnt_nxt = CNT_LOAD;
        end else if (r_cnt == '0) begin
          w_state_nxt = RUN;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      MEM_WAIT: begin
        // A misprediction during the wait is deferred until the access completes.
        if (dmem_ack) begin
          if (r_pend | branch_fail) begin
            w_state_nxt = FLUSH;
            w_cnt_nxt   = CNT_LOAD;
          end else begin
            w_state_nxt = RUN;
          end
        end else begin
          w_stall[STALL_MEM] = 1'b1;
          if (branch_fail) w_pend_nxt = 1'b1;
        end
      end
      SLEEP: begin
        w_stall[STALL_SLEEP] = 1'b1;
        if (branch_fail) begin
          w_state_nxt = FLUSH;
          w_cnt_nxt   = CNT_LOAD;
        end else if (wake) begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
    if (w_state_nxt == FLUSH && r_state != FLUSH) w_pend_nxt = 1'b0;
  end

  // Outputs are forced low while reset is held so they clear without waiting for a clock.
  assign stall_o      = rst ? '0 : w_stall;
  assign clear_o      = ~rst & w_clear;
  assign fetch_hold_o = |stall_o;
  assign state_o      = r_state;

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] r_perf_stall;
  logic [PERF_W-1:0] r_perf_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (fetch_hold_o && r_perf_stall != '1) r_perf_stall <= r_perf_stall + PERF_W'(1);
      if (w_state_nxt == FLUSH && r_state != FLUSH && r_perf_flush != '1)
        r_perf_flush <= r_perf_flush + PERF_W'(1);
    end
  end

  assign perf_stall_o = r_perf_stall;
  assign perf_flush_o = r_perf_flush;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (FLUSH_CYCLES=2).
module tb_pipeline_hazard_ctrl;

  logic              clk;
  logic              rst;
  logic [40:0]       dec_enable;
  logic [2:0]        dec_D, dec_S;
  logic              dec_rd_d, dec_rd_s, dec_RC;
  logic [2:0][40:0]  stg_enable;
  logic [2:0][2:0]   stg_D, stg_S;
  logic [2:0]        stg_ptr_upd, stg_slp;
  logic              branch_fail, dmem_req, dmem_ack, wake;
  logic [7:0]        stall_o;
  logic              clear_o, fetch_hold_o;
  logic [1:0]        state_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [15:0]       perf_stall_o, perf_flush_o;
`endif

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] S_RUN = 2'd0, S_FLUSH = 2'd1, S_MW = 2'd2, S_SLEEP = 2'd3;
  localparam logic [40:0] EN_ADD = 41'h1 << 9;
  localparam logic [40:0] EN_LD  = 41'h1 << 33;
  localparam logic [40:0] EN_ST  = 41'h1 << 34;
  localparam logic [40:0] EN_SLP = 41'h1 << 40;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .dec_enable(dec_enable), .dec_D(dec_D), .dec_S(dec_S),
    .dec_rd_d(dec_rd_d), .dec_rd_s(dec_rd_s), .dec_RC(dec_RC),
    .stg_enable(stg_enable), .stg_D(stg_D), .stg_S(stg_S),
    .stg_ptr_upd(stg_ptr_upd), .stg_slp(stg_slp),
    .branch_fail(branch_fail), .dmem_req(dmem_req), .dmem_ack(dmem_ack), .wake(wake),
    .stall_o(stall_o), .clear_o(clear_o), .fetch_hold_o(fetch_hold_o), .state_o(state_o)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_stall_o(perf_stall_o), .perf_flush_o(perf_flush_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dec_enable = '0; dec_D = '0; dec_S = '0;
    dec_rd_d = 1'b0; dec_rd_s = 1'b0; dec_RC = 1'b0;
    stg_enable = '0; stg_D = '0; stg_S = '0;
    stg_ptr_upd = '0; stg_slp = '0;
    branch_fail = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0; wake = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #2;
    checks++; if (stall_o !== 8'h00) begin errors++; $display("FAIL reset_stall got=%h exp=00", stall_o); end
    checks++; if (clear_o !== 1'b0) begin errors++; $display("FAIL reset_clear got=%b exp=0", clear_o); end
    checks++; if (state_o !== S_RUN) begin errors++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_raw();
    dec_enable = EN_ADD; dec_rd_d = 1'b1; dec_D = 3'd1;
    dec_rd_s = 1'b1; dec_S = 3'd3; dec_RC = 1'b0;
    stg_enable[0] = EN_ADD; stg_D[0] = 3'd3;
    #1;
    checks++; if (stall_o !== 8'h01) begin errors++; $display("FAIL raw_exec got=%h exp=01", stall_o); end
    checks++; if (fetch_hold_o !== 1'b1) begin errors++; $display("FAIL raw_hold got=%b exp=1", fetch_hold_o); end
    tick();
    stg_enable[1] = stg_enable[0]; stg_D[1] = stg_D[0]; stg_enable[0] = '0; stg_D[0] = '0;
    #1;
    checks++; if (stall_o !== 8'h02) begin errors++; $display("FAIL raw_mem got=%h exp=02", stall_o); end
    tick();
    stg_enable[2] = stg_enable[1]; stg_D[2] = stg_D[1]; stg_enable[1] = '0; stg_D[1] = '0;
    #1;
    checks++; if (stall_o !== 8'h04) begin errors++; $display("FAIL raw_wb got=%h exp=04", stall_o); end
    tick();
    stg_enable[2] = '0; stg_D[2] = '0;
    #1;
    checks++; if (stall_o !== 8'h00) begin errors++; $display("FAIL raw_after_wb got=%h exp=00", stall_o); end
    checks++; if (fetch_hold_o !== 1'b0) begin errors++; $display("FAIL raw_after_hold got=%b exp=0", fetch_hold_o); end
    tick();
  endtask

  task automatic test_raw_variants();
    stg_enable[0] = EN_ADD; stg_D[0] = 3'd3;
    dec_enable = EN_ADD; dec_rd_d = 1'b1; dec_D = 3'd1; dec_rd_s = 1'b1; dec_S = 3'd3; dec_RC = 1'b1;
    #1;
    checks++; if (stall_o !== 8'h00) begin errors++; $display("FAIL raw_const got=%h exp=00", stall_o); end
    dec_RC = 1'b0; dec_enable = '0;
    #1;
    checks++; if (stall_o !== 8'h00) begin errors++; $display("FAIL raw_no_dec got=%h exp=00", stall_o); end
    dec_enable = EN_ADD; dec_rd_s = 1'b0; dec_rd_d = 1'b1; dec_D = 3'd3;
    #1;
    checks++; if (stall_o !== 8'h01) begin errors++; $display("FAIL raw_src_d got=%h exp=01", stall_o); end
    stg_enable[0] = '0; stg_D[0] = '0;
    // LD with pointer update writes its S register back (mem stage).
    stg_enable[1] = EN_LD; stg_D[1] = 3'd5; stg_S[1] = 3'd3; stg_ptr_upd[1] = 1'b1;
    #1;
    checks++; if (stall_o !== 8'h02) begin errors++; $display("FAIL raw_ld_ptr got=%h exp=02", stall_o); end
    stg_ptr_upd[1] = 1'b0;
    #1;
    checks++; if (stall_o !== 8'h00) begin errors++; $display("FAIL raw_ld_noptr got=%h exp=00", stall_o); end
    stg_enable[1] = '0; stg_D[1] = '0; stg_S[1] = '0;
    // ST never writes D unless the pointer is updated (wb stage).
    stg_enable[2] = EN_ST; stg_D[2] = 3'd3; stg_ptr_upd[2] = 1'b0;
    #1;
    checks++; if (stall_o !== 8'h00) begin errors++; $display("FAIL raw_st_noptr got=%h exp=00", stall_o); end
    stg_ptr_upd[2] = 1'b1;
    #1;
    checks++; if (stall_o !== 8'h04) begin errors++; $display("FAIL raw_st_ptr got=%h exp=04", stall_o); end
    idle_inputs();
    tick();
  endtask

  task automatic test_flush();
    int n;
    // Keep a RAW producer alive to show stall is masked during FLUSH.
    stg_enable[0] = EN_ADD; stg_D[0] = 3'd2;
    dec_enable = EN_ADD; dec_rd_d = 1'b1; dec_D = 3'd2;
    branch_fail = 1'b1;
    #1;
    checks++; if (clear_o !== 1'b0) begin errors++; $display("FAIL flush_pulse_clear got=%b exp=0", clear_o); end
    tick();
    branch_fail = 1'b0;
    #1;
    checks++; if (state_o !== S_FLUSH) begin errors++; $display("FAIL flush_c1_state got=%0d exp=1", state_o); end
    checks++; if (clear_o !== 1'b1) begin errors++; $display("FAIL flush_c1_clear got=%b exp=1", clear_o); end
    checks++; if (stall_o !== 8'h00) begin errors++; $display("FAIL flush_c1_stall got=%h exp=00", stall_o); end
    tick();
    #1;
    checks++; if (clear_o !== 1'b1) begin errors++; $display("FAIL flush_c2_clear got=%b exp=1", clear_o); end
    tick();
    #1;
    checks++; if (clear_o !== 1'b0) begin errors++; $display("FAIL flush_end_clear got=%b exp=0", clear_o); end
    checks++; if (state_o !== S_RUN) begin errors++; $display("FAIL flush_end_state got=%0d exp=0", state_o); end
    idle_inputs();
    tick();
    // Second pulse during the first FLUSH cycle restarts the count: 3 cycles total.
    branch_fail = 1'b1;
    tick();
    #1;
    checks++; if (clear_o !== 1'b1) begin errors++; $display("FAIL flush2_c1_clear got=%b exp=1", clear_o); end
    tick();
    branch_fail = 1'b0;
    n = 1;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (clear_o !== 1'b1) break;
      n++;
      tick();
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL flush2_len got=%0d exp=3", n); end
    checks++; if (state_o !== S_RUN) begin errors++; $display("FAIL flush2_state got=%0d exp=0", state_o); end
    tick();
  endtask

  task automatic test_mem_wait();
    int n;
    stg_enable[0] = EN_ADD; stg_D[0] = 3'd4;
    dec_enable = EN_ADD; dec_rd_d = 1'b1; dec_D = 3'd4;
    dmem_req = 1'b1;
    #1;
    checks++; if (stall_o !== 8'h09) begin errors++; $display("FAIL mem_raw_both got=%h exp=09", stall_o); end
    n = 0;
    for (int k = 0; k < 3; k++) begin
      if (stall_o[3] === 1'b1) n++;
      tick();
      if (k == 0) begin
        idle_inputs();
        dmem_req = 1'b1;
      end
      if (k == 2) dmem_ack = 1'b1;
      #1;
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL mem_wait_len got=%0d exp=3", n); end
    checks++; if (stall_o !== 8'h00) begin errors++; $display("FAIL mem_ack_stall got=%h exp=00", stall_o); end
    checks++; if (state_o !== S_MW) begin errors++; $display("FAIL mem_ack_state got=%0d exp=2", state_o); end
    tick();
    dmem_req = 1'b0; dmem_ack = 1'b0;
    #1;
    checks++; if (state_o !== S_RUN) begin errors++; $display("FAIL mem_done_state got=%0d exp=0", state_o); end
    tick();
    dmem_req = 1'b1;
    tick();
    branch_fail = 1'b1;
    #1;
    checks++; if (stall_o !== 8'h08 || clear_o !== 1'b0) begin errors++; $display("FAIL mem_bf_wait got=%h/%b exp=08/0", stall_o, clear_o); end
    tick();
    branch_fail = 1'b0;
    dmem_ack = 1'b1;
    #1;
    checks++; if (state_o !== S_MW || clear_o !== 1'b0) begin errors++; $display("FAIL mem_bf_ack got=%0d/%b exp=2/0", state_o, clear_o); end
    tick();
    dmem_req = 1'b0; dmem_ack = 1'b0;
    #1;
    checks++; if (state_o !== S_FLUSH || clear_o !== 1'b1) begin errors++; $display("FAIL mem_bf_flush got=%0d/%b exp=1/1", state_o, clear_o); end
    tick(); tick();
    #1;
    checks++; if (state_o !== S_RUN) begin errors++; $display("FAIL mem_bf_run got=%0d exp=0", state_o); end
    tick();
  endtask

  task automatic test_sleep();
    stg_enable[2] = EN_SLP; stg_slp[2] = 1'b1;
    #1;
    checks++; if (stall_o !== 8'h00 || state_o !== S_RUN) begin errors++; $display("FAIL slp_enter got=%h/%0d exp=00/0", stall_o, state_o); end
    tick();
    #1;
    checks++; if (stall_o !== 8'h10 || fetch_hold_o !== 1'b1) begin errors++; $display("FAIL slp_stall got=%h/%b exp=10/1", stall_o, fetch_hold_o); end
    tick();
    #1;
    checks++; if (stall_o !== 8'h10) begin errors++; $display("FAIL slp_hold got=%h exp=10", stall_o); end
    wake = 1'b1; stg_enable[2] = '0; stg_slp[2] = 1'b0;
    #1;
    checks++; if (state_o !== S_SLEEP) begin errors++; $display("FAIL slp_wake_cycle got=%0d exp=3", state_o); end
    tick();
    wake = 1'b0;
    #1;
    checks++; if (state_o !== S_RUN || stall_o !== 8'h00) begin errors++; $display("FAIL slp_woke got=%0d/%h exp=0/00", state_o, stall_o); end
    stg_enable[2] = EN_SLP; stg_slp[2] = 1'b1;
    tick();
    stg_enable[2] = '0; stg_slp[2] = 1'b0;
    branch_fail = 1'b1;
    tick();
    branch_fail = 1'b0;
    #1;
    checks++; if (state_o !== S_FLUSH || clear_o !== 1'b1) begin errors++; $display("FAIL slp_bf got=%0d/%b exp=1/1", state_o, clear_o); end
    tick(); tick();
  endtask

  task automatic test_reset_mid_wait();
    dmem_req = 1'b1;
    tick();
    #1;
    checks++; if (state_o !== S_MW) begin errors++; $display("FAIL rst_pre_state got=%0d exp=2", state_o); end
    rst = 1'b1;
    #1;
    checks++; if (stall_o !== 8'h00 || clear_o !== 1'b0 || fetch_hold_o !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs got=%h/%b/%b exp=00/0/0", stall_o, clear_o, fetch_hold_o); end
    checks++; if (state_o !== S_RUN) begin errors++; $display("FAIL rst_mid_state got=%0d exp=0", state_o); end
    tick();
    idle_inputs();
    rst = 1'b0;
    tick();
  endtask

`ifdef PIPE_CTRL_PERF_EN
  task automatic test_perf();
    rst = 1'b1;
    #1;
    checks++; if (perf_stall_o !== 16'h0 || perf_flush_o !== 16'h0) begin errors++; $display("FAIL perf_reset got=%h/%h exp=0/0", perf_stall_o, perf_flush_o); end
    tick();
    rst = 1'b0;
    branch_fail = 1'b1;
    tick();
    branch_fail = 1'b0;
    tick(); tick();
    checks++; if (perf_flush_o !== 16'h1 || perf_stall_o !== 16'h0) begin errors++; $display("FAIL perf_flush got=%h/%h exp=1/0", perf_flush_o, perf_stall_o); end
    stg_enable[2] = EN_SLP; stg_slp[2] = 1'b1;
    for (int k = 0; k < 65600; k++) tick();
    checks++; if (perf_stall_o !== 16'hFFFF) begin errors++; $display("FAIL perf_sat got=%h exp=ffff", perf_stall_o); end
    idle_inputs();
    wake = 1'b1;
    tick();
    wake = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_raw();
    test_raw_variants();
    test_flush();
    test_mem_wait();
    test_sleep();
    test_reset_mid_wait();
`ifdef PIPE_CTRL_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
